apb_master_arb: RTL and testbench
=================================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one APB4 master port.
REQ-002 Parameter TIMEOUT, default 16, maximum ACCESS cycles waiting for PREADY before abort.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: PCLK input 1, rising-edge clock; PRESET input 1, synchronous active-high reset.
REQ-004 req_transfer input [NUM_REQ] SHALL carry per-requester transfer requests, held high until that requester's req_done.
REQ-005 req_write input [NUM_REQ] SHALL carry per-requester write(1)/read(0).
REQ-006 req_addr, req_wdata input [NUM_REQ][32] SHALL carry per-requester address and write data.
REQ-007 req_strb input [NUM_REQ][4], req_prot input [NUM_REQ][3] SHALL carry per-requester byte strobes and protection.
REQ-008 req_grant output [NUM_REQ] SHALL be one-hot, marking the requester owning the bus.
REQ-009 req_done output [NUM_REQ] SHALL be a one-cycle completion pulse.
REQ-010 req_rdata output 32, req_slverr output 1 SHALL carry the completion response, valid while any req_done is high.
REQ-011 PSEL, PENABLE, PWRITE output 1; PADDR, PWDATA output 32; PSTRB output 4; PPROT output 3 SHALL form the APB4 master outputs.
REQ-012 PRDATA input 32, PREADY input 1, PSLVERR input 1 SHALL be the APB4 slave responses.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-014 IDLE: if any unmasked req_transfer is high at an edge, the FSM SHALL select a winner round-robin, latch its command, and enter SETUP; otherwise it stays in IDLE.
REQ-015 Round-robin: priority SHALL start at the requester after the last granted one, wrapping NUM_REQ-1 -> 0.
REQ-016 Masking: in a cycle where req_done[g] is high, req_transfer[g] SHALL be ignored for arbitration.
REQ-017 SETUP: PSEL=1, PENABLE=0; the FSM SHALL enter ACCESS unconditionally after one cycle.
REQ-018 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA, PSTRB and PPROT SHALL stay constant from SETUP through the end of ACCESS.
REQ-019 PSTRB SHALL be 4'b0000 for reads regardless of req_strb.
REQ-020 ACCESS with PREADY=1 at an edge: the FSM SHALL enter IDLE, and in the next cycle req_done[g]=1, req_rdata=PRDATA (0 for writes) and req_slverr=PSLVERR, all registered.
REQ-021 A 5-bit wait counter SHALL clear on entering ACCESS and increment on each ACCESS edge with PREADY=0.
REQ-022 When the wait counter reaches TIMEOUT-1 with PREADY=0 at an edge: abort to IDLE, req_done[g]=1, req_slverr=1, req_rdata=0.
REQ-023 req_grant[g] SHALL be high exactly during SETUP and ACCESS of g's transfer.
REQ-024 Minimum IDLE gap between transfers SHALL be 1 cycle, giving 3 cycles per zero-wait transfer.
REQ-025 In IDLE, PSEL=0, PENABLE=0, and the address/data outputs SHALL hold their last values.

Reset
REQ-026 PRESET=1 at an edge SHALL force IDLE, the round-robin pointer to give requester 0 highest priority, and the wait counter to 0.
REQ-027 On reset, all outputs SHALL be 0.
REQ-028 Reset mid-SETUP or mid-ACCESS SHALL abandon the transfer without a req_done pulse.

Structure
REQ-029 Package apb_pkg SHALL hold the state enum, the NUM_REQ default, the TIMEOUT default and the wait counter width.
REQ-030 Sub-module apb_rr_arbiter (combinational; inputs req vector and last-grant pointer, output one-hot winner) SHALL implement REQ-015.
REQ-031 Total RTL SHALL be 150-300 lines.

Verification
REQ-032 Read, zero-wait: req0 read 0x10, PREADY=1 in ACCESS, PRDATA=0xDEADBEEF -> PSEL 2 cycles, req_done[0] on the 3rd cycle with rdata 0xDEADBEEF, slverr 0.
REQ-033 Write, 2 waits: req1 write 0x20 data 0x12345678 strb 0xF, PREADY low 2 cycles -> PADDR, PWDATA and PSTRB stable for 4 cycles, then req_done[1].
REQ-034 Contention: req0 and req1 both high from reset -> grant order 0,1,0,1 across 4 transfers.
REQ-035 Timeout: PREADY tied 0 -> abort after 16 ACCESS cycles, req_slverr=1, req_rdata=0, PSEL drops.
REQ-036 Mid-transfer reset: PRESET=1 in ACCESS -> next cycle all outputs 0, no req_done; first grant after reset goes to req0.
REQ-037 Read strobes: read with req_strb=0xF -> PSTRB=0; PSLVERR=1 with PREADY=1 -> req_slverr=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the arbitrated APB4 master.
package apb_pkg;

  localparam int unsigned NumReqDefault  = 2;
  localparam int unsigned TimeoutDefault = 16;
  localparam int unsigned WaitCntW       = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin arbiter: the requester after `last` has highest priority.
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // Walk NUM_REQ positions starting one past the last grant, wrapping to 0.
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      idx = IDX_W'((int'(last) + i) % int'(NUM_REQ));
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB4 master shared by NUM_REQ requesters with round-robin arbitration and a
// PREADY timeout that aborts the transfer with an error response.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NUM_REQ-1:0]       req_transfer,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  input  logic [NUM_REQ-1:0][3:0]  req_strb,
  input  logic [NUM_REQ-1:0][2:0]  req_prot,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [31:0]              req_rdata,
  output logic                     req_slverr,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  output logic [2:0]               PPROT,
  input  logic [31:0]              PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_state_e          state_q;
  logic [IdxW-1:0]     last_q;
  logic [IdxW-1:0]     cur_q;
  logic [IdxW-1:0]     win_idx;
  logic [WaitCntW-1:0] wait_q;
  logic [NUM_REQ-1:0]  masked_req;
  logic [NUM_REQ-1:0]  win;

  // A requester whose done pulse is out this cycle has not yet dropped its request.
  assign masked_req = req_transfer & ~req_done;

  apb_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IdxW)
  ) u_arb (
    .req (masked_req),
    .last(last_q),
    .gnt (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win[i]) win_idx = IdxW'(i);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= StIdle;
      last_q     <= IdxW'(NUM_REQ - 1);
      cur_q      <= '0;
      wait_q     <= '0;
      req_grant  <= '0;
      req_done   <= '0;
      req_rdata  <= '0;
      req_slverr <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      PPROT      <= '0;
    end else begin
      req_done <= '0;
      unique case (state_q)
        StIdle: begin
          if (|masked_req) begin
            state_q   <= StSetup;
            last_q    <= win_idx;
            cur_q     <= win_idx;
            req_grant <= win;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= req_write[win_idx];
            PADDR     <= req_addr[win_idx];
            PWDATA    <= req_wdata[win_idx];
            PSTRB     <= req_write[win_idx] ? req_strb[win_idx] : 4'b0000;
            PPROT     <= req_prot[win_idx];
          end
        end
        StSetup: begin
          state_q <= StAccess;
          PENABLE <= 1'b1;
          wait_q  <= '0;
        end
        StAccess: begin
          if (PREADY) begin
            state_q         <= StIdle;
            PSEL            <= 1'b0;
            PENABLE         <= 1'b0;
            req_grant       <= '0;
            req_done[cur_q] <= 1'b1;
            req_rdata       <= PWRITE ? 32'h0 : PRDATA;
            req_slverr      <= PSLVERR;
          end else if (wait_q == WaitCntW'(TIMEOUT - 1)) begin
            state_q         <= StIdle;
            PSEL            <= 1'b0;
            PENABLE         <= 1'b0;
            req_grant       <= '0;
            req_done[cur_q] <= 1'b1;
            req_rdata       <= 32'h0;
            req_slverr      <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: expected completions are queued when a
// transfer is launched and matched against each req_done pulse.
module tb_apb_master_arb;

  localparam int unsigned NReq = 2;
  localparam int unsigned Tmo  = 16;

  logic                  PCLK = 1'b0;
  logic                  PRESET;
  logic [NReq-1:0]       req_transfer;
  logic [NReq-1:0]       req_write;
  logic [NReq-1:0][31:0] req_addr;
  logic [NReq-1:0][31:0] req_wdata;
  logic [NReq-1:0][3:0]  req_strb;
  logic [NReq-1:0][2:0]  req_prot;
  logic [NReq-1:0]       req_grant;
  logic [NReq-1:0]       req_done;
  logic [31:0]           req_rdata;
  logic                  req_slverr;
  logic                  PSEL, PENABLE, PWRITE;
  logic [31:0]           PADDR, PWDATA, PRDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  logic                  PREADY, PSLVERR;

  // Slave model configuration.
  int          slv_waits;
  logic        slv_hang;
  logic        slv_err;
  logic [31:0] slv_rdata;
  int          acc_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 PCLK = ~PCLK;

  assign PRDATA  = slv_rdata;
  assign PSLVERR = slv_err;

  apb_master_arb #(
    .NUM_REQ(NReq),
    .TIMEOUT(Tmo)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_transfer(req_transfer),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_prot    (req_prot),
    .req_grant   (req_grant),
    .req_done    (req_done),
    .req_rdata   (req_rdata),
    .req_slverr  (req_slverr),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PPROT       (PPROT),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave: PREADY rises on ACCESS cycle number slv_waits unless hung.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY = !slv_hang && (acc_cnt == slv_waits);
      acc_cnt++;
    end else begin
      PREADY  = 1'b0;
      acc_cnt = 0;
    end
  end

  // Completion monitor.
  always @(negedge PCLK) begin
    if (req_done != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(req_done), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("done_id", 64'(req_done), 64'(1) << mon_e.id);
        chk("done_rdata", 64'(req_rdata), 64'(mon_e.rdata));
        chk("done_slverr", 64'(req_slverr), 64'(mon_e.err));
      end
    end
  end

  task automatic push_exp(input int id, input logic [31:0] rd, input logic err);
    exp_t e;
    e.id    = id;
    e.rdata = rd;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, 64'({PSEL, PENABLE, PWRITE, PSTRB, PPROT, req_grant, req_done,
                            req_slverr}), 64'(0));
    chk({tag, "_paddr"}, 64'(PADDR), 64'(0));
    chk({tag, "_pwdata"}, 64'(PWDATA), 64'(0));
    chk({tag, "_rdata"}, 64'(req_rdata), 64'(0));
  endtask

  // Single-requester transfer from an idle bus; checks command stability,
  // grant, PSEL length and done latency.
  task automatic xfer(input string tag, input int id, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input int waits, input logic hang, input logic err);
    int psel_cyc;
    int exp_cyc;
    bit seen;
    slv_waits = waits;
    slv_hang  = hang;
    slv_err   = err;
    exp_cyc   = hang ? int'(Tmo) + 1 : waits + 2;
    push_exp(id, (wr || hang) ? 32'h0 : slv_rdata, hang ? 1'b1 : err);
    @(negedge PCLK);
    req_write[id]    = wr;
    req_addr[id]     = addr;
    req_wdata[id]    = wdata;
    req_strb[id]     = strb;
    req_prot[id]     = prot;
    req_transfer[id] = 1'b1;
    psel_cyc = 0;
    seen     = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge PCLK);
      if (PSEL) begin
        psel_cyc++;
        chk({tag, "_paddr"}, 64'(PADDR), 64'(addr));
        chk({tag, "_pwdata"}, 64'(PWDATA), 64'(wdata));
        chk({tag, "_pstrb"}, 64'(PSTRB), 64'(wr ? strb : 4'b0000));
        chk({tag, "_pwrite"}, 64'(PWRITE), 64'(wr));
        chk({tag, "_pprot"}, 64'(PPROT), 64'(prot));
        chk({tag, "_grant"}, 64'(req_grant), 64'(1) << id);
      end
      if (req_done[id]) begin
        seen             = 1;
        req_transfer[id] = 1'b0;
        chk({tag, "_psel_cyc"}, 64'(psel_cyc), 64'(exp_cyc));
        chk({tag, "_latency"}, 64'(c), 64'(exp_cyc));
        chk({tag, "_psel_drop"}, 64'({PSEL, PENABLE, req_grant}), 64'(0));
      end
    end
    if (!seen) chk({tag, "_no_done"}, 64'(0), 64'(1));
  endtask

  int order[4] = '{0, 1, 0, 1};
  int n_setup;
  int n_done;
  bit hit;

  initial begin
    PRESET       = 1'b1;
    req_transfer = '0;
    req_write    = '0;
    req_addr     = '0;
    req_wdata    = '0;
    req_strb     = '0;
    req_prot     = '0;
    slv_waits    = 0;
    slv_hang     = 1'b0;
    slv_err      = 1'b0;
    slv_rdata    = 32'h0;
    PREADY       = 1'b0;
    acc_cnt      = 0;
    repeat (2) @(negedge PCLK);
    check_reset_outs("rst");
    PRESET = 1'b0;

    slv_rdata = 32'hDEADBEEF;
    xfer("rd0_zw", 0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0);
    xfer("wr1_2w", 1, 1'b1, 32'h20, 32'h12345678, 4'hF, 3'b010, 2, 1'b0, 1'b0);
    xfer("wr0_prot", 0, 1'b1, 32'h44, 32'hCAFE0001, 4'h3, 3'b101, 0, 1'b0, 1'b0);
    slv_rdata = 32'h600DF00D;
    xfer("rd0_strb_err", 0, 1'b0, 32'h88, 32'h55AA55AA, 4'hF, 3'b001, 1, 1'b0, 1'b1);
    xfer("tmo1", 1, 1'b0, 32'h9C, 32'h0, 4'h0, 3'b000, 0, 1'b1, 1'b0);

    // Contention: both requesters high from reset.
    slv_hang  = 1'b0;
    slv_waits = 0;
    slv_err   = 1'b0;
    slv_rdata = 32'hA5A50000;
    req_write = '0;
    for (int k = 0; k < 4; k++) push_exp(order[k], 32'hA5A50000, 1'b0);
    @(negedge PCLK);
    PRESET       = 1'b1;
    req_transfer = 2'b11;
    repeat (2) @(negedge PCLK);
    PRESET  = 1'b0;
    n_setup = 0;
    n_done  = 0;
    for (int c = 0; c < 60 && n_done < 4; c++) begin
      @(negedge PCLK);
      if (PSEL && !PENABLE && n_setup < 4) begin
        chk("cont_grant", 64'(req_grant), 64'(1) << order[n_setup]);
        n_setup++;
      end
      if (req_done != '0) begin
        n_done++;
        if (n_done == 4) req_transfer = '0;
      end
    end
    chk("cont_dones", 64'(n_done), 64'(4));

    // Reset in ACCESS abandons the transfer; priority returns to requester 0.
    slv_hang        = 1'b1;
    req_write[0]    = 1'b0;
    req_transfer[0] = 1'b1;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge PCLK);
      if (PENABLE) hit = 1;
    end
    chk("mrst_reach_access", 64'(hit), 64'(1));
    PRESET       = 1'b1;
    req_transfer = '0;
    @(negedge PCLK);
    check_reset_outs("mrst");
    slv_hang  = 1'b0;
    slv_rdata = 32'h0BADF00D;
    push_exp(0, 32'h0BADF00D, 1'b0);
    push_exp(1, 32'h0BADF00D, 1'b0);
    PRESET       = 1'b0;
    req_transfer = 2'b11;
    @(negedge PCLK);
    chk("mrst_first_grant", 64'({PSEL, req_grant}), 64'({1'b1, 2'b01}));
    n_done = 0;
    for (int c = 0; c < 40 && n_done < 2; c++) begin
      @(negedge PCLK);
      if (req_done[0]) req_transfer[0] = 1'b0;
      if (req_done[1]) req_transfer[1] = 1'b0;
      if (req_done != '0) n_done++;
    end
    chk("mrst_dones", 64'(n_done), 64'(2));

    repeat (3) @(negedge PCLK);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
